dec_counter: RTL and testbench

//  Loadable down-counter: a start value is accepted over a valid/ready handshake and counted down to zero.
//  The decrement path is a parallel-prefix borrow-lookahead decrementer, the counterpart of the

---
 rtl/dec_counter.sv | 118 +++++++++++
 tb/tb_dec_counter.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/dec_counter.sv
// Loadable down-counter with a prefix-AND borrow-lookahead decrementer and a 1-cycle Done pulse.
// Optional feature: define DEC_COUNTER_AUTORELOAD_EN for periodic reload from the last start value.

package lau_pkg;
    typedef enum logic {Slow, Fast} speed_e;
endpackage

module dec_counter #(
    parameter int unsigned      Width = 8,
    parameter lau_pkg::speed_e  Speed = lau_pkg::Fast
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             ld_valid_i,
    output logic             ld_ready_o,
    input  logic [Width-1:0] ld_data_i,
    input  logic             en_i,
    input  logic             clr_i,
    output logic [Width-1:0] cnt_o,
    output logic             busy_o,
    output logic             zero_o,
    output logic             done_o
);

    localparam int unsigned Levels = $clog2(Width);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e           state_q;
    logic [Width-1:0] cnt_q;
    logic             done_q;
    logic [Width-1:0] po;
    logic [Width-1:0] dec_d;
    logic             handshake;

`ifdef DEC_COUNTER_AUTORELOAD_EN
    logic [Width-1:0] reload_q;
`endif

    // po[i] = &(~cnt_q[i:0]); bit i of the result flips when every lower bit is zero
    if (Speed == lau_pkg::Fast) begin : g_prefix_fast
        logic [Width-1:0] nxt;
        always_comb begin
            po  = ~cnt_q;
            nxt = '0;
            for (int l = 0; l < int'(Levels); l++) begin
                nxt = po;
                for (int i = (1 << l); i < int'(Width); i++) begin
                    nxt[i] = po[i] & po[i - (1 << l)];
                end
                po = nxt;
            end
        end
    end else begin : g_prefix_slow
        always_comb begin
            po = ~cnt_q;
            for (int i = 1; i < int'(Width); i++) begin
                po[i] = po[i-1] & po[i];
            end
        end
    end

    assign dec_d     = cnt_q ^ {po[Width-2:0], 1'b1};
    assign handshake = ld_valid_i & ld_ready_o;

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            done_q  <= 1'b0;
`ifdef DEC_COUNTER_AUTORELOAD_EN
            if (rst_i) begin
                reload_q <= '0;
            end
`endif
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (handshake) begin
                        cnt_q <= ld_data_i;
`ifdef DEC_COUNTER_AUTORELOAD_EN
                        reload_q <= ld_data_i;
`endif
                        if (ld_data_i != '0) begin
                            state_q <= StRun;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                StRun: begin
                    if (en_i) begin
                        if (cnt_q == Width'(1)) begin
                            done_q <= 1'b1;
`ifdef DEC_COUNTER_AUTORELOAD_EN
                            cnt_q <= reload_q;
`else
                            cnt_q   <= dec_d;
                            state_q <= StIdle;
`endif
                        end else begin
                            cnt_q <= dec_d;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign ld_ready_o = (state_q == StIdle) & ~clr_i;
    assign busy_o     = (state_q == StRun);
    assign zero_o     = (cnt_q == '0);
    assign cnt_o      = cnt_q;
    assign done_o     = done_q;

endmodule

// File: tb/tb_dec_counter.sv
// Directed vector bench for dec_counter (Width=8); follows DEC_COUNTER_AUTORELOAD_EN when defined.

module tb_dec_counter;

    logic       clk = 1'b0;
    logic       rst, ld_valid, en, clr;
    logic [7:0] ld_data;
    logic       ld_ready, busy, zero, done;
    logic [7:0] cnt;

    int n_vec = 0;
    int n_err = 0;

    dec_counter #(.Width(8), .Speed(lau_pkg::Fast)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .ld_valid_i (ld_valid),
        .ld_ready_o (ld_ready),
        .ld_data_i  (ld_data),
        .en_i       (en),
        .clr_i      (clr),
        .cnt_o      (cnt),
        .busy_o     (busy),
        .zero_o     (zero),
        .done_o     (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       rst;
        logic       lv;
        logic [7:0] data;
        logic       en;
        logic       clr;
        logic [7:0] cnt;
        logic       busy;
        logic       zero;
        logic       done;
        logic       rdy;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic lv, logic [7:0] d, logic e, logic c,
                                logic [7:0] xc, logic xb, logic xz, logic xd, logic xr);
        vec_t v;
        v.rst = r; v.lv = lv; v.data = d; v.en = e; v.clr = c;
        v.cnt = xc; v.busy = xb; v.zero = xz; v.done = xd; v.rdy = xr;
        return v;
    endfunction

    task automatic apply(input int idx, input vec_t v);
        rst = v.rst; ld_valid = v.lv; ld_data = v.data; en = v.en; clr = v.clr;
        @(posedge clk);
        #1;
        n_vec++;
        if ({cnt, busy, zero, done, ld_ready} !== {v.cnt, v.busy, v.zero, v.done, v.rdy}) begin
            n_err++;
            $display("FAIL vec%0d: got cnt=%h busy=%b zero=%b done=%b rdy=%b, want cnt=%h busy=%b zero=%b done=%b rdy=%b",
                     idx, cnt, busy, zero, done, ld_ready, v.cnt, v.busy, v.zero, v.done, v.rdy);
        end
    endtask

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    initial begin
        bit found;
        rst = 1'b1; ld_valid = 1'b0; ld_data = '0; en = 1'b0; clr = 1'b0;

        // fields: rst lv data en clr | cnt busy zero done rdy
        vecs.push_back(mk(1, 0, 8'd0,   0, 0, 8'd0,   0, 1, 0, 1));
        vecs.push_back(mk(1, 0, 8'd0,   0, 0, 8'd0,   0, 1, 0, 1));
`ifndef DEC_COUNTER_AUTORELOAD_EN
        // one-shot run of 5
        vecs.push_back(mk(0, 1, 8'd5,   1, 0, 8'd5,   1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 8'd0,   1, 0, 8'd4,   1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 8'd0,   1, 0, 8'd3,   1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 8'd0,   1, 0, 8'd2,   1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 8'd0,   1, 0, 8'd1,   1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 8'd0,   1, 0, 8'd0,   0, 1, 1, 1));
        vecs.push_back(mk(0, 0, 8'd0,   0, 0, 8'd0,   0, 1, 0, 1));
        // borrow across all bits, then abort
        vecs.push_back(mk(0, 1, 8'h80,  1, 0, 8'h80,  1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 8'd0,   1, 0, 8'h7F,  1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 8'd0,   0, 1, 8'd0,   0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 8'h01,  1, 0, 8'h01,  1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 8'd0,   1, 0, 8'd0,   0, 1, 1, 1));
        // gated counting: En 1,0,0,1,1
        vecs.push_back(mk(0, 1, 8'd3,   0, 0, 8'd3,   1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 8'd0,   1, 0, 8'd2,   1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 8'd0,   0, 0, 8'd2,   1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 8'd0,   0, 0, 8'd2,   1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 8'd0,   1, 0, 8'd1,   1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 8'd0,   1, 0, 8'd0,   0, 1, 1, 1));
        // zero load
        vecs.push_back(mk(0, 1, 8'd0,   0, 0, 8'd0,   0, 1, 1, 1));
        vecs.push_back(mk(0, 0, 8'd0,   0, 0, 8'd0,   0, 1, 0, 1));
        // load 10, abort at 6
        vecs.push_back(mk(0, 1, 8'd10,  1, 0, 8'd10,  1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 8'd0,   1, 0, 8'd9,   1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 8'd0,   1, 0, 8'd8,   1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 8'd0,   1, 0, 8'd7,   1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 8'd0,   1, 0, 8'd6,   1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 8'd0,   1, 1, 8'd0,   0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 8'd0,   0, 0, 8'd0,   0, 1, 0, 1));
        // Clr beats LdValid
        vecs.push_back(mk(0, 1, 8'd7,   0, 1, 8'd0,   0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 8'd0,   0, 0, 8'd0,   0, 1, 0, 1));
        // terminal count with LdValid pending: accepted in the Done cycle
        vecs.push_back(mk(0, 1, 8'd2,   1, 0, 8'd2,   1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 8'd9,   1, 0, 8'd1,   1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 8'd9,   1, 0, 8'd0,   0, 1, 1, 1));
        vecs.push_back(mk(0, 1, 8'd9,   0, 0, 8'd9,   1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 8'd0,   1, 0, 8'd0,   0, 1, 0, 1));
`else
        // periodic reload of 3
        vecs.push_back(mk(0, 1, 8'd3,   1, 0, 8'd3,   1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 8'd9,   1, 0, 8'd2,   1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 8'd0,   1, 0, 8'd1,   1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 8'd9,   1, 0, 8'd3,   1, 0, 1, 0));
        vecs.push_back(mk(0, 0, 8'd0,   1, 0, 8'd2,   1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 8'd0,   0, 0, 8'd2,   1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 8'd0,   1, 0, 8'd1,   1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 8'd0,   1, 0, 8'd3,   1, 0, 1, 0));
        vecs.push_back(mk(0, 0, 8'd0,   1, 0, 8'd2,   1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 8'd0,   1, 0, 8'd0,   0, 1, 0, 1));
        // zero load still pulses Done and stays idle
        vecs.push_back(mk(0, 1, 8'd0,   1, 0, 8'd0,   0, 1, 1, 1));
        vecs.push_back(mk(0, 0, 8'd0,   1, 0, 8'd0,   0, 1, 0, 1));
        // Clr is the exit from RUN
        vecs.push_back(mk(0, 1, 8'd4,   1, 0, 8'd4,   1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 8'd7,   1, 1, 8'd0,   0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 8'd0,   0, 0, 8'd0,   0, 1, 0, 1));
`endif
        for (int i = 0; i < vecs.size(); i++) apply(i, vecs[i]);

        // long run: Done exactly 200 enabled cycles after loading 200
        rst = 1'b0; clr = 1'b0; ld_valid = 1'b1; ld_data = 8'd200; en = 1'b1;
        @(posedge clk); #1;
        chk("long_load", cnt, 8'd200);
        ld_valid = 1'b0;
        found = 1'b0;
        for (int k = 1; k <= 250 && !found; k++) begin
            @(posedge clk); #1;
            if (done) begin
                found = 1'b1;
                chk("long_done_cycle", 8'(k), 8'd200);
`ifdef DEC_COUNTER_AUTORELOAD_EN
                chk("long_done_cnt", cnt, 8'd200);
`else
                chk("long_done_cnt", cnt, 8'd0);
`endif
            end else if (k < 200) begin
                chk("long_cnt", cnt, 8'(200 - k));
            end
        end
        if (!found) begin
            n_vec++;
            n_err++;
            $display("FAIL long_timeout: got no Done within 250 cycles, want Done at cycle 200");
        end
        clr = 1'b1; en = 1'b0;
        @(posedge clk); #1;
        clr = 1'b0;

        // single decrement from every start value 2..255
        for (int v = 2; v < 256; v++) begin
            ld_valid = 1'b1; ld_data = 8'(v); en = 1'b0;
            @(posedge clk); #1;
            ld_valid = 1'b0; en = 1'b1;
            @(posedge clk); #1;
            chk($sformatf("dec_%0d", v), cnt, 8'(v - 1));
            en = 1'b0; clr = 1'b1;
            @(posedge clk); #1;
            clr = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
